// File: rtl/diverge_ctrl.sv
// rtl/diverge_ctrl.sv - SIMT branch-divergence controller sequencing the predicate stack
// Optional statistics counters are enabled by defining DIVERGE_STATS_EN.
module diverge_ctrl #(
  parameter int N_CORES  = 4,
  parameter int DEPTH    = 8,
  parameter int PC_WIDTH = 8,
  localparam int DW      = $clog2(DEPTH) + 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                if_valid,
  input  logic                else_valid,
  input  logic                endif_valid,
  input  logic [N_CORES-1:0]  cond,
  input  logic [PC_WIDTH-1:0] br_target,
  output logic                ready,
  input  logic [N_CORES-1:0]  ps_q,
  input  logic                ps_all_true,
  input  logic                ps_all_false,
  output logic [N_CORES-1:0]  ps_d,
  output logic                ps_push,
  output logic                ps_pop,
  output logic                ps_comp,
  output logic                pc_load,
  output logic [PC_WIDTH-1:0] pc_target,
  output logic [DW-1:0]       depth,
  output logic                err_overflow,
  output logic                err_underflow,
`ifdef DIVERGE_STATS_EN
  output logic [15:0]         div_count,
  output logic [15:0]         uniform_count,
`endif
  output logic                err_multi
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_SETTLE, S_RESOLVE} state_t;
  typedef enum logic [1:0] {K_IF, K_ELSE, K_ENDIF} kind_t;

  localparam logic [DW-1:0] FULL = DW'(DEPTH);
  localparam logic [DW-1:0] ONE  = DW'(1);

  state_t              state;
  kind_t               kind;
  logic [PC_WIDTH-1:0] target;
  logic                any_valid;
  logic                multi_valid;

  assign any_valid   = if_valid | else_valid | endif_valid;
  assign multi_valid = (if_valid & else_valid) | (if_valid & endif_valid) |
                       (else_valid & endif_valid);

`ifndef DIVERGE_STATS_EN
  logic unused_all_true;
  assign unused_all_true = ps_all_true;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= S_IDLE;
      kind          <= K_IF;
      target        <= '0;
      ready         <= 1'b1;
      ps_d          <= '0;
      ps_push       <= 1'b0;
      ps_pop        <= 1'b0;
      ps_comp       <= 1'b0;
      pc_load       <= 1'b0;
      pc_target     <= '0;
      depth         <= '0;
      err_overflow  <= 1'b0;
      err_underflow <= 1'b0;
      err_multi     <= 1'b0;
`ifdef DIVERGE_STATS_EN
      div_count     <= '0;
      uniform_count <= '0;
`endif
    end else begin
      // Strobes are single-cycle; only the state that raises one re-asserts it.
      ps_push <= 1'b0;
      ps_pop  <= 1'b0;
      ps_comp <= 1'b0;
      pc_load <= 1'b0;
      case (state)
        S_IDLE: begin
          if (any_valid) begin
            if (multi_valid) err_multi <= 1'b1;
            if (if_valid) begin
              if (depth == FULL) begin
                err_overflow <= 1'b1;
              end else begin
                kind    <= K_IF;
                target  <= br_target;
                ps_d    <= cond & ps_q;
                ps_push <= 1'b1;
                depth   <= depth + ONE;
                ready   <= 1'b0;
                state   <= S_ISSUE;
              end
            end else if (depth == '0) begin
              err_underflow <= 1'b1;
            end else if (else_valid) begin
              kind    <= K_ELSE;
              target  <= br_target;
              ps_comp <= 1'b1;
              ready   <= 1'b0;
              state   <= S_ISSUE;
            end else begin
              kind   <= K_ENDIF;
              target <= br_target;
              ps_pop <= 1'b1;
              depth  <= depth - ONE;
              ready  <= 1'b0;
              state  <= S_ISSUE;
            end
          end
        end
        S_ISSUE: state <= S_SETTLE;
        S_SETTLE: begin
          // Stack flags are valid now; register the redirect so it shows in RESOLVE.
          state <= S_RESOLVE;
          if (kind != K_ENDIF && ps_all_false) begin
            pc_load   <= 1'b1;
            pc_target <= target;
          end
`ifdef DIVERGE_STATS_EN
          if (kind == K_IF) begin
            if (!ps_all_true && !ps_all_false && div_count != 16'hFFFF)
              div_count <= div_count + 16'd1;
            if (ps_all_true && uniform_count != 16'hFFFF)
              uniform_count <= uniform_count + 16'd1;
          end
`endif
        end
        S_RESOLVE: begin
          state <= S_IDLE;
          ready <= 1'b1;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_diverge_ctrl.sv
// tb/tb_diverge_ctrl.sv - directed self-checking bench for diverge_ctrl
module tb_diverge_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       if_valid, else_valid, endif_valid;
  logic [3:0] cond;
  logic [7:0] br_target;
  logic       ready;
  logic [3:0] ps_q;
  logic       ps_all_true, ps_all_false;
  logic [3:0] ps_d;
  logic       ps_push, ps_pop, ps_comp;
  logic       pc_load;
  logic [7:0] pc_target;
  logic [3:0] depth;
  logic       err_overflow, err_underflow, err_multi;
`ifdef DIVERGE_STATS_EN
  logic [15:0] div_count, uniform_count;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  diverge_ctrl #(.N_CORES(4), .DEPTH(8), .PC_WIDTH(8)) dut (
    .clk(clk), .reset(reset),
    .if_valid(if_valid), .else_valid(else_valid), .endif_valid(endif_valid),
    .cond(cond), .br_target(br_target), .ready(ready),
    .ps_q(ps_q), .ps_all_true(ps_all_true), .ps_all_false(ps_all_false),
    .ps_d(ps_d), .ps_push(ps_push), .ps_pop(ps_pop), .ps_comp(ps_comp),
    .pc_load(pc_load), .pc_target(pc_target), .depth(depth),
    .err_overflow(err_overflow), .err_underflow(err_underflow),
`ifdef DIVERGE_STATS_EN
    .div_count(div_count), .uniform_count(uniform_count),
`endif
    .err_multi(err_multi)
  );

  // Called at a falling edge; returns at the falling edge inside the ISSUE cycle.
  task automatic send(input logic iv, input logic ev, input logic nv,
                      input logic [3:0] c, input logic [7:0] t);
    if_valid = iv; else_valid = ev; endif_valid = nv; cond = c; br_target = t;
    @(posedge clk);
    @(negedge clk);
    if_valid = 1'b0; else_valid = 1'b0; endif_valid = 1'b0;
  endtask

  task automatic wait_neg(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic apply_reset;
    @(negedge clk);
    reset = 1'b1;
    wait_neg(2);
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset;
    if_valid = 0; else_valid = 0; endif_valid = 0; cond = 0; br_target = 0;
    ps_q = 4'b1111; ps_all_true = 0; ps_all_false = 0;
    reset = 1'b1;
    wait_neg(2);
    checks++; if (ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b exp 1", ready); end
    checks++; if ({ps_push, ps_pop, ps_comp, pc_load} !== 4'b0000) begin errors++; $display("FAIL reset_strobes: got %b exp 0000", {ps_push, ps_pop, ps_comp, pc_load}); end
    checks++; if ({ps_d, depth, pc_target} !== 16'h0) begin errors++; $display("FAIL reset_data: got %h exp 0000", {ps_d, depth, pc_target}); end
    checks++; if ({err_overflow, err_underflow, err_multi} !== 3'b000) begin errors++; $display("FAIL reset_err: got %b exp 000", {err_overflow, err_underflow, err_multi}); end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_if_else_endif;
    send(1, 0, 0, 4'b1010, 8'h20);
    checks++; if ({ps_push, ps_comp, ps_pop} !== 3'b100) begin errors++; $display("FAIL if_strobe: got %b exp 100", {ps_push, ps_comp, ps_pop}); end
    checks++; if (ps_d !== 4'b1010) begin errors++; $display("FAIL if_ps_d: got %b exp 1010", ps_d); end
    checks++; if (ready !== 1'b0) begin errors++; $display("FAIL if_busy: got %b exp 0", ready); end
    ps_q = 4'b1010; ps_all_false = 0;
    wait_neg(1);
    checks++; if ({ps_push, ps_d} !== 5'b0_1010) begin errors++; $display("FAIL settle_push: got %b exp 01010", {ps_push, ps_d}); end
    wait_neg(1);
    checks++; if ({pc_load, ready} !== 2'b00) begin errors++; $display("FAIL if_resolve: got %b exp 00", {pc_load, ready}); end
    wait_neg(1);
    checks++; if ({ready, depth} !== 5'b1_0001) begin errors++; $display("FAIL if_done: got %b exp 10001", {ready, depth}); end

    send(0, 1, 0, 4'b0000, 8'h30);
    checks++; if ({ps_push, ps_comp, ps_pop, depth} !== 7'b010_0001) begin errors++; $display("FAIL else_strobe: got %b exp 0100001", {ps_push, ps_comp, ps_pop, depth}); end
    ps_q = 4'b0101;
    wait_neg(2);
    checks++; if (pc_load !== 1'b0) begin errors++; $display("FAIL else_no_load: got %b exp 0", pc_load); end
    wait_neg(1);

    send(0, 0, 1, 4'b0000, 8'h00);
    checks++; if ({ps_push, ps_comp, ps_pop, depth} !== 7'b001_0000) begin errors++; $display("FAIL endif_strobe: got %b exp 0010000", {ps_push, ps_comp, ps_pop, depth}); end
    ps_q = 4'b1111;
    wait_neg(2);
    checks++; if (pc_load !== 1'b0) begin errors++; $display("FAIL endif_no_load: got %b exp 0", pc_load); end
    wait_neg(1);
    checks++; if (ready !== 1'b1) begin errors++; $display("FAIL endif_ready: got %b exp 1", ready); end
  endtask

  task automatic test_redirect;
    send(1, 0, 0, 4'b0000, 8'h44);
    checks++; if ({ps_push, ps_d} !== 5'b1_0000) begin errors++; $display("FAIL redir_push: got %b exp 10000", {ps_push, ps_d}); end
    ps_q = 4'b0000; ps_all_false = 1;
    wait_neg(1);
    checks++; if (pc_load !== 1'b0) begin errors++; $display("FAIL redir_early: got %b exp 0", pc_load); end
    wait_neg(1);
    checks++; if ({pc_load, pc_target} !== 9'h1_44) begin errors++; $display("FAIL redir_load: got %h exp 144", {pc_load, pc_target}); end
    wait_neg(1);
    checks++; if ({pc_load, ready} !== 2'b01) begin errors++; $display("FAIL redir_one_cycle: got %b exp 01", {pc_load, ready}); end
    // ENDIF with all_false still high must not redirect.
    send(0, 0, 1, 4'b0000, 8'h55);
    wait_neg(2);
    checks++; if (pc_load !== 1'b0) begin errors++; $display("FAIL endif_never_load: got %b exp 0", pc_load); end
    wait_neg(1);
    ps_q = 4'b1111; ps_all_false = 0;
  endtask

  task automatic test_overflow_underflow;
    for (int i = 0; i < 8; i++) begin
      send(1, 0, 0, 4'b1111, 8'h10);
      wait_neg(3);
    end
    checks++; if (depth !== 4'd8) begin errors++; $display("FAIL full_depth: got %0d exp 8", depth); end
    checks++; if (err_overflow !== 1'b0) begin errors++; $display("FAIL overflow_early: got %b exp 0", err_overflow); end
    send(1, 0, 0, 4'b1111, 8'h10);
    checks++; if ({ps_push, ready, err_overflow, depth} !== 7'b011_1000) begin errors++; $display("FAIL overflow: got %b exp 0111000", {ps_push, ready, err_overflow, depth}); end
    for (int i = 0; i < 8; i++) begin
      send(0, 0, 1, 4'b0000, 8'h00);
      wait_neg(3);
    end
    checks++; if ({depth, err_underflow} !== 5'b0000_0) begin errors++; $display("FAIL empty_depth: got %b exp 00000", {depth, err_underflow}); end
    send(0, 0, 1, 4'b0000, 8'h00);
    checks++; if ({ps_pop, ready, err_underflow, depth} !== 7'b011_0000) begin errors++; $display("FAIL underflow: got %b exp 0110000", {ps_pop, ready, err_underflow, depth}); end
    send(0, 1, 0, 4'b0000, 8'h00);
    checks++; if ({ps_comp, ready, err_overflow} !== 3'b011) begin errors++; $display("FAIL else_underflow: got %b exp 011", {ps_comp, ready, err_overflow}); end
  endtask

  task automatic test_multi_and_async_reset;
    checks++; if (err_multi !== 1'b0) begin errors++; $display("FAIL multi_early: got %b exp 0", err_multi); end
    send(1, 0, 1, 4'b0110, 8'h66);
    checks++; if ({ps_push, ps_pop, ps_d, err_multi} !== 7'b10_0110_1) begin errors++; $display("FAIL multi: got %b exp 1001101", {ps_push, ps_pop, ps_d, err_multi}); end
    wait_neg(3);
    checks++; if (depth !== 4'd1) begin errors++; $display("FAIL multi_depth: got %0d exp 1", depth); end
    send(1, 0, 0, 4'b1111, 8'h77);
    wait_neg(1);
    #1 reset = 1'b1;
    #1;
    checks++; if ({ready, ps_push, ps_pop, ps_comp, pc_load} !== 5'b10000) begin errors++; $display("FAIL async_ctrl: got %b exp 10000", {ready, ps_push, ps_pop, ps_comp, pc_load}); end
    checks++; if ({depth, ps_d, err_overflow, err_underflow, err_multi} !== 11'h0) begin errors++; $display("FAIL async_data: got %b exp 0", {depth, ps_d, err_overflow, err_underflow, err_multi}); end
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    checks++; if (ready !== 1'b1) begin errors++; $display("FAIL post_reset_ready: got %b exp 1", ready); end
    // Back-to-back: accepted on the first edge after ready returns.
    send(1, 0, 0, 4'b0011, 8'h88);
    checks++; if ({ps_push, ps_d, depth} !== 9'b1_0011_0001) begin errors++; $display("FAIL post_reset_if: got %b exp 100110001", {ps_push, ps_d, depth}); end
    wait_neg(3);
  endtask

`ifdef DIVERGE_STATS_EN
  task automatic test_stats;
    apply_reset;
    ps_q = 4'b1111; ps_all_true = 0; ps_all_false = 0;
    send(1, 0, 0, 4'b1010, 8'h20);
    wait_neg(3);
    checks++; if ({div_count, uniform_count} !== {16'd1, 16'd0}) begin errors++; $display("FAIL stats_div: got %h exp 00010000", {div_count, uniform_count}); end
    send(1, 0, 0, 4'b1111, 8'h21);
    ps_all_true = 1;
    wait_neg(3);
    checks++; if ({div_count, uniform_count} !== {16'd1, 16'd1}) begin errors++; $display("FAIL stats_uniform: got %h exp 00010001", {div_count, uniform_count}); end
    ps_all_true = 0;
  endtask
`endif

  initial begin
    test_reset;
    test_if_else_endif;
    test_redirect;
    test_overflow_underflow;
    test_multi_and_async_reset;
`ifdef DIVERGE_STATS_EN
    test_stats;
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
